// File: rtl/elephant_pstep2_inv.sv
// elephant_pstep2_inv
// Sequential inverse of the Elephant pstep2 byte-permutation step. A request
// carries the (x, y) pair produced by up to seven forward swapmove steps plus
// the step list; the unit undoes one step per clock, starting from the last
// forward step and working back to the first, then presents the recovered pair.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload while valid is high and ready is
// low. The unit holds rsp_* stable while rsp_valid is high and rsp_ready is low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_x, req_y         forward-output word pair
//   req_seq              seven 3-bit step codes, field 0 applied first forward
//   req_len              number of valid step codes (0..7)
//   rsp_valid/rsp_ready  response handshake (valid only in DONE)
//   rsp_x, rsp_y         recovered word pair
//   rsp_err              a processed step code was 7 (not invertible)
//   busy                 high in RUN or DONE
module elephant_pstep2_inv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [20:0] req_seq,
  input  logic [2:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_y,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [20:0] seq_q;
  logic [2:0]  idx_q;
  logic        err_q;

  logic [2:0]  code;
  logic [31:0] x_rot;
  logic [63:0] sm_res;
  logic [31:0] step_x;
  logic [31:0] step_y;
  logic        step_err;

  // Swapmove on (a, b): returns {a', b'}. Self-inverse for the masks used here.
  function automatic logic [63:0] sm(input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] s, input logic [31:0] m);
    logic [31:0] t;
    t = (b ^ (a >> s)) & m;
    return {a ^ (t << s), b ^ t};
  endfunction

  // Current step code, selected by idx (idx never reaches 7).
  always_comb begin
    code = 3'd0;
    case (idx_q)
      3'd0: code = seq_q[2:0];
      3'd1: code = seq_q[5:3];
      3'd2: code = seq_q[8:6];
      3'd3: code = seq_q[11:9];
      3'd4: code = seq_q[14:12];
      3'd5: code = seq_q[17:15];
      3'd6: code = seq_q[20:18];
      default: code = 3'd0;
    endcase
  end

  // One inverse step. Codes 4..6 first rotate X right to undo the forward
  // rotate-left of the x output, then apply the swapmove.
  always_comb begin
    x_rot    = x_q;
    sm_res   = {x_q, y_q};
    step_err = err_q;
    case (code)
      3'd0: sm_res = sm(x_q, y_q, 5'd8,  32'h0000_00FF);
      3'd1: sm_res = sm(x_q, y_q, 5'd16, 32'h0000_00FF);
      3'd2: sm_res = sm(x_q, y_q, 5'd24, 32'h0000_00FF);
      3'd3: sm_res = sm(x_q, y_q, 5'd8,  32'h0000_FF00);
      3'd4: begin
        x_rot  = {x_q[7:0], x_q[31:8]};
        sm_res = sm(x_rot, y_q, 5'd24, 32'h0000_00FF);
      end
      3'd5: begin
        x_rot  = {x_q[15:0], x_q[31:16]};
        sm_res = sm(x_rot, y_q, 5'd16, 32'h0000_FF00);
      end
      3'd6: begin
        x_rot  = {x_q[23:0], x_q[31:24]};
        sm_res = sm(x_rot, y_q, 5'd8, 32'h00FF_0000);
      end
      default: step_err = 1'b1;  // code 7: pair left unchanged
    endcase
    step_x = sm_res[63:32];
    step_y = sm_res[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rsp_x   <= '0;
      rsp_y   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_q   <= req_x;
            y_q   <= req_y;
            seq_q <= req_seq;
            err_q <= 1'b0;
            if (req_len == 3'd0) begin
              state   <= DONE;
              rsp_x   <= req_x;
              rsp_y   <= req_y;
              rsp_err <= 1'b0;
            end else begin
              idx_q <= req_len - 3'd1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          x_q   <= step_x;
          y_q   <= step_y;
          err_q <= step_err;
          if (idx_q == 3'd0) begin
            state   <= DONE;
            rsp_x   <= step_x;
            rsp_y   <= step_y;
            rsp_err <= step_err;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

endmodule
